wbu: RTL
========

Name: wbu

Overview:
- Write-back stage directly downstream of the load/store unit. Takes the memory-stage result (ALU result or load data from the LSU), buffers it in a 2-entry skid buffer with valid/ready handshakes, and drives the register-file write port and commit/retire outputs.
- Also provides combinational bypass lookup for two source-register IDs against its buffered, not-yet-written results.

Parameters:
- CPU_WIDTH, 64, datapath width; fixed to match `CPU_WIDTH.
- REG_ADDRW, 5, register index width.
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_pre_valid  input  1  upstream (LSU stage) result valid.
- o_pre_ready  output  1  wbu can accept a result.
- i_pc  input  CPU_WIDTH  PC of the incoming instruction.
- i_rdid  input  REG_ADDRW  destination register.
- i_rdwen  input  1  instruction writes rd.
- i_lden  input  1  1 = take i_regld, 0 = take i_exres.
- i_exres  input  CPU_WIDTH  execute result / address.
- i_regld  input  CPU_WIDTH  extended load data from the LSU.
- o_post_valid  output  1  head entry ready to commit.
- i_post_ready  input  1  commit consumer (regfile/difftest) accepts the head.
- o_rdwen  output  1  regfile write strobe.
- o_rdid  output  REG_ADDRW  regfile write index.
- o_rd  output  CPU_WIDTH  regfile write data.
- o_commit_pc  output  CPU_WIDTH  PC of the committing instruction.
- o_instret  output  CNT_WIDTH  retired-instruction count.
- i_rs1id, i_rs2id  input  REG_ADDRW  bypass query indices.
- o_rs1_hit, o_rs2_hit  output  1  query matches a pending write.
- o_rs1_data, o_rs2_data  output  CPU_WIDTH  bypass data.

Behaviour:
- Data selection at the input: wbdata = i_lden ? i_regld : i_exres. Stored per entry as {pc, rdid, rdwen, wbdata}.
- An entry's effective write enable is rdwen & (rdid != 0). This is computed at capture time, so x0 writes are never stored as writes.
- Handshakes:
  - in_fire = i_pre_valid & o_pre_ready.
  - out_fire = o_post_valid & i_post_ready.
  - Payload is sampled only on in_fire. Upstream must hold the payload stable while valid & !ready.
- State machine (registered state, entries "head" and "skid"):
  - EMPTY:
    - in_fire → ONE, head <= input.
  - ONE:
    - in_fire & out_fire → ONE, head <= input.
    - in_fire only → FULL, skid <= input.
    - out_fire only → EMPTY.
    - neither → hold.
  - FULL:
    - in_fire is impossible, since o_pre_ready = 0.
    - out_fire → ONE, head <= skid.
    - else hold.
- o_pre_ready = (state != FULL). It is decoded from registered state only, with no combinational path from i_post_ready.
- o_post_valid = (state != EMPTY). Head fields drive o_commit_pc.
- Latency: a result accepted on edge N is visible at the outputs after edge N, and commits on the first edge with i_post_ready = 1 thereafter. Throughput is 1/cycle when i_post_ready is held high.
- Regfile port:
  - o_rdwen = out_fire & head.wen.
  - o_rdid = head.rdid.
  - o_rd = head.data.
  - o_rdwen is never 1 for rdid 0.
- o_instret increments by 1 on every out_fire and wraps at 2^CNT_WIDTH to 0.
- Bypass (combinational, per query port), in priority order:
  1. If skid is valid, skid.wen = 1 and skid.rdid = query → hit, skid data (younger entry wins).
  2. Else if head is valid, head.wen = 1 and head.rdid = query → hit, head data.
  3. Else hit = 0, data = 0.
  - Query index 0 always misses.
- Simultaneous in_fire and out_fire in ONE: the committing head is written to the regfile on the same edge that the new head is loaded; no bubble.
- Reset (async, i_rst_n low), effective immediately:
  - state = EMPTY; head and skid are invalid, with all fields 0.
  - o_post_valid = 0; o_rdwen = 0; o_pre_ready = 1.
  - o_instret = 0; o_rd, o_rdid and o_commit_pc = 0.
  - A reset asserted mid-handshake discards both entries; no write is issued.

Test Plan:
- Back-to-back flow: i_post_ready = 1, send 4 results (pc 0x80000000 + 4k, rd = 1..4, i_lden alternating, i_exres = 0x10 + k, i_regld = 0xFFFF_FFFF_FFFF_FF80 + k) → one commit per cycle, 1-cycle latency; o_rd alternates load/ALU data; o_instret = 4.
- Backpressure: i_post_ready = 0, send 3 valid results → the first two are accepted; o_pre_ready = 0 after the 2nd; the third is held. Raising i_post_ready → commits in order A, B, C with no loss or duplication.
- x0 write: i_rdid = 0, i_rdwen = 1, data 0xDEAD → commit with o_rdwen = 0; o_instret increments; a bypass query on rs1 = 0 → hit = 0.
- Bypass priority: head {rd = 5, data = 0x11}, skid {rd = 5, data = 0x22}, i_rs1id = 5 → o_rs1_hit = 1, o_rs1_data = 0x22. After the head commits → still 0x22. After both commit → hit = 0.
- Reset mid-operation: FULL state with i_post_ready = 0, assert i_rst_n = 0 asynchronously between edges → outputs clear immediately (o_post_valid = 0, o_pre_ready = 1, o_instret = 0). After release, no stale commit occurs.
- Counter wrap: with CNT_WIDTH = 4, commit 17 instructions → o_instret reads 15 then 0 then 1.

Source files
------------

// File: rtl/wbu.sv
`default_nettype none
// ============================================================================
//  Module   : wbu
//  Purpose  : Write-back stage. A 2-entry skid buffer between the LSU and the
//             register-file write port, with commit/retire outputs and a
//             bypass lookup over results that are buffered but not yet written.
//  Revision : 1.0 - initial release
// ============================================================================
module wbu #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic [REG_ADDRW-1:0] i_rdid,
    input  logic                 i_rdwen,
    input  logic                 i_lden,
    input  logic [CPU_WIDTH-1:0] i_exres,
    input  logic [CPU_WIDTH-1:0] i_regld,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic                 o_rdwen,
    output logic [REG_ADDRW-1:0] o_rdid,
    output logic [CPU_WIDTH-1:0] o_rd,
    output logic [CPU_WIDTH-1:0] o_commit_pc,
    output logic [CNT_WIDTH-1:0] o_instret,
    input  logic [REG_ADDRW-1:0] i_rs1id,
    input  logic [REG_ADDRW-1:0] i_rs2id,
    output logic                 o_rs1_hit,
    output logic                 o_rs2_hit,
    output logic [CPU_WIDTH-1:0] o_rs1_data,
    output logic [CPU_WIDTH-1:0] o_rs2_data
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] pc;
        logic [REG_ADDRW-1:0] rdid;
        logic                 wen;
        logic [CPU_WIDTH-1:0] data;
    } entry_t;

    state_t               r_state;
    state_t               w_state_nxt;
    entry_t               r_head;
    entry_t               r_skid;
    entry_t               w_in_entry;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_load_head_in;
    logic                 w_load_head_skid;
    logic                 w_load_skid;
    logic                 w_head_vld;
    logic                 w_skid_vld;
    logic [CNT_WIDTH-1:0] r_instret;

    // Ready depends only on registered state, so no ready path runs through.
    assign o_pre_ready  = (r_state != S_FULL);
    assign o_post_valid = (r_state != S_EMPTY);
    assign w_in_fire    = i_pre_valid & o_pre_ready;
    assign w_out_fire   = o_post_valid & i_post_ready;
    assign w_head_vld   = (r_state != S_EMPTY);
    assign w_skid_vld   = (r_state == S_FULL);

    always_comb begin
        w_in_entry.pc   = i_pc;
        w_in_entry.rdid = i_rdid;
        w_in_entry.wen  = i_rdwen & (i_rdid != '0);
        w_in_entry.data = i_lden ? i_regld : i_exres;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = S_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_head_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = S_ONE;
                    w_load_head_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head <= w_in_entry;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instret <= '0;
        end else if (w_out_fire) begin
            r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    assign o_rdwen     = w_out_fire & r_head.wen;
    assign o_rdid      = r_head.rdid;
    assign o_rd        = r_head.data;
    assign o_commit_pc = r_head.pc;
    assign o_instret   = r_instret;

    // Skid is the younger entry, so it is checked first.
    function automatic logic [CPU_WIDTH:0] f_lookup(
        input logic [REG_ADDRW-1:0] query,
        input logic                 head_vld,
        input entry_t               head,
        input logic                 skid_vld,
        input entry_t               skid
    );
        logic [CPU_WIDTH:0] res;
        res = '0;
        if (query != '0) begin
            if (skid_vld && skid.wen && (skid.rdid == query)) begin
                res = {1'b1, skid.data};
            end else if (head_vld && head.wen && (head.rdid == query)) begin
                res = {1'b1, head.data};
            end
        end
        return res;
    endfunction

    assign {o_rs1_hit, o_rs1_data} = f_lookup(i_rs1id, w_head_vld, r_head, w_skid_vld, r_skid);
    assign {o_rs2_hit, o_rs2_data} = f_lookup(i_rs2id, w_head_vld, r_head, w_skid_vld, r_skid);

endmodule
`default_nettype wire
